vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Scan sequencer for the VGA output path. Runs a horizontal and a vertical phase state machine that generate sync pulses, the active-video window and the pixel coordinates for the upstream pixel generator. It also registers the generator's RGB with blanking applied, so that colour, `hs` and `vs` leave the block aligned on the same clock edge. The block sits between the POR/reset logic and the PMOD colour/sync pins.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BACK`, 33: vertical back porch, in lines

Ports:
- `clk`  in  1: single system clock
- `rst`  in  1: asynchronous, active-high reset
- `pix_ce`  in  1: pixel-rate enable; when low, all state holds
- `x`  out  10: current column; valid when `de`=1
- `y`  out  10: current line; valid when `de`=1
- `de`  out  1: active-video window for the current `x`/`y`
- `line_start`  out  1: one-cycle pulse at `x`=0 of every line
- `frame_start`  out  1: one-cycle pulse at `x`=0, `y`=0
- `r_in`, `g_in`, `b_in`  in  4 each: generator colour for the current `x`/`y`
- `r`, `g`, `b`  out  4 each: registered colour, blanked outside the active window
- `hs`, `vs`  out  1 each: sync outputs, active-low

## Operation
- Horizontal FSM: H_ACT → H_FP → H_SYN → H_BP → H_ACT.
  - A phase counter counts one per `pix_ce`.
  - The FSM leaves a state when the counter reaches `<phase length>-1`, and the counter then clears.
- Vertical FSM: V_ACT → V_FP → V_SYN → V_BP → V_ACT.
  - It advances only on the `pix_ce` cycle that ends H_BP, so the line counter and vertical state change together with `x`→0.
- `x` counts 0..`H_ACTIVE`-1 in H_ACT and holds its last value outside it. `y` behaves the same way for V_ACT.
- `de` = (H state is H_ACT) and (V state is V_ACT). It is registered and aligned with `x`/`y`.
- The generator drives `r_in`/`g_in`/`b_in` combinationally from `x`/`y` within the same cycle.
- On each `pix_ce` cycle the block registers:
  - `r`/`g`/`b` ← `de` ? inputs : 0
  - `hs` ← not (H state is H_SYN)
  - `vs` ← not (V state is V_SYN)
- Counter width is 10 bits. The design requires each phase length ≥1 and each total ≤1024; an elaboration-time check enforces this.
- While `pix_ce`=0, every register holds, including the pulses. `line_start`/`frame_start` are qualified by `pix_ce`: they are asserted only on a `pix_ce` cycle.
- Defaults: 800 clocks per line, 525 lines per frame, 420000 `pix_ce` cycles per frame.

## Timing
Reset values (asynchronous assert):
- H and V FSMs in H_ACT/V_ACT with counters at 0, so `x`=0, `y`=0
- `de`=0, `r`/`g`/`b`=0, `hs`=1, `vs`=1, `line_start`=0, `frame_start`=0

After reset:
- The first `pix_ce` cycle after `rst` deasserts presents `x`=0, `y`=0, `de`=1 and pulses `line_start` and `frame_start`.
- Latency from `x`/`y` to `r`/`g`/`b`/`hs`/`vs` is 1 `pix_ce` cycle.

Boundary conditions:
- End of frame (H_BP last pixel while in V_BP last line): next `pix_ce` gives `x`=0, `y`=0, `frame_start`=1.
- Reset mid-line or mid-frame: outputs return to reset values immediately. The scan restarts at `x`=0, `y`=0 with no partial-frame recovery.
- `pix_ce` low for many cycles mid-sync: the sync width in `pix_ce` cycles is unchanged.

## Configuration
- `VGA_FRAME_COUNT_EN`
  - Defined: adds output `frame_cnt` (8 bits, reset 0). It increments on each `frame_start` and wraps from 255 to 0.
  - Undefined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Package `vga_pkg` holds:
  - the `vga_phase_t` enum (ACT, FP, SYN, BP)
  - default timing localparams for 640x480@60
  - the 10-bit coordinate width constant
- Sub-module `vga_axis_seq` implements one phase FSM plus counter, with ports `advance` and `wrap`.
  - Instantiate it twice: the horizontal instance is driven by `pix_ce`; the vertical instance is driven by the horizontal `wrap`.

## Test plan
- Reset release with `pix_ce`=1 → first cycle `x`=0, `y`=0, `de`=1, `frame_start`=1; `hs`=`vs`=1.
- One line with defaults → `de` high for 640 cycles, `hs` low for exactly 96 cycles, starting 656 cycles after `line_start`. Line period is 800.
- One frame → `vs` low for 2×800 cycles, starting at line 490. `frame_start` period is 420000 cycles.
- `r_in`=0xF throughout → `r`=0xF only while the delayed `de` is 1, 0 elsewhere. `r` transitions coincide with the `hs`-aligned cycle.
- `pix_ce` toggling 1/0 → all periods double in clocks and outputs hold on `pix_ce`=0.
- Assert `rst` at `x`=300, `y`=200 → immediate reset values. After release, the scan restarts at 0/0. With `VGA_FRAME_COUNT_EN`, `frame_cnt` returns to 0 and reads 1 after the next full frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan sequencer: phase encoding,
// coordinate width and the default 640x480@60 timing.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   typedef enum logic [1:0] {
      PH_ACT,
      PH_FP,
      PH_SYN,
      PH_BP
   } vga_phase_t;

   // Phase order is fixed: active, front porch, sync, back porch, then back to active.
   function automatic vga_phase_t nextPhase(input vga_phase_t p);
      vga_phase_t n;
      case (p)
         PH_ACT:  n = PH_FP;
         PH_FP:   n = PH_SYN;
         PH_SYN:  n = PH_BP;
         default: n = PH_ACT;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// One scan axis: a four-phase FSM with a phase counter. The counter steps on
// each 'advance'; when it reaches the phase length minus one it clears and the
// FSM moves on. 'wrap' flags the advance that ends the back porch, which is
// what steps the other axis.
module vga_axis_seq
   import vga_pkg::*;
#(
   parameter int ACT_LEN = DEF_H_ACTIVE,
   parameter int FP_LEN  = DEF_H_FRONT,
   parameter int SYN_LEN = DEF_H_SYNC,
   parameter int BP_LEN  = DEF_H_BACK
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               advance,
   output vga_phase_t         phase_o,
   output logic [COORD_W-1:0] count_o,
   output logic               wrap
);

   localparam logic [COORD_W-1:0] LAST_ACT = COORD_W'(ACT_LEN - 1);
   localparam logic [COORD_W-1:0] LAST_FP  = COORD_W'(FP_LEN - 1);
   localparam logic [COORD_W-1:0] LAST_SYN = COORD_W'(SYN_LEN - 1);
   localparam logic [COORD_W-1:0] LAST_BP  = COORD_W'(BP_LEN - 1);

   vga_phase_t         phase_q, phase_d;
   logic [COORD_W-1:0] count_q, count_d;
   logic [COORD_W-1:0] phaseLast;

   // Phase and counter registers; reset lands at the start of the active phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_ACT;
         count_q <= '0;
      end else begin
         phase_q <= phase_d;
         count_q <= count_d;
      end
   end

   // Next phase/count and the end-of-axis wrap strobe.
   always_comb begin
      phaseLast = LAST_ACT;
      phase_d   = phase_q;
      count_d   = count_q;
      wrap      = 1'b0;
      case (phase_q)
         PH_ACT:  phaseLast = LAST_ACT;
         PH_FP:   phaseLast = LAST_FP;
         PH_SYN:  phaseLast = LAST_SYN;
         default: phaseLast = LAST_BP;
      endcase
      if (advance) begin
         if (count_q == phaseLast) begin
            count_d = '0;
            phase_d = nextPhase(phase_q);
            wrap    = (phase_q == PH_BP);
         end else begin
            count_d = count_q + COORD_W'(1);
         end
      end
   end

   assign phase_o = phase_q;
   assign count_o = count_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: horizontal and vertical phase FSMs, registered pixel
// coordinates / active window / line and frame pulses, and a second register
// stage that carries blanked colour and the active-low syncs so they leave
// the block together. Optional macro VGA_FRAME_COUNT_EN adds an 8-bit
// wrapping frame counter output 'frame_cnt'.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_ce,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               de,
   output logic               line_start,
   output logic               frame_start,
   input  logic [3:0]         r_in,
   input  logic [3:0]         g_in,
   input  logic [3:0]         b_in,
   output logic [3:0]         r,
   output logic [3:0]         g,
   output logic [3:0]         b,
   output logic               hs,
   output logic               vs
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [7:0]         frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Every phase must last at least one step and an axis must fit the 10-bit counter.
   if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
       H_TOTAL > 1024 || V_TOTAL > 1024) begin : gBadTiming
      $error("vga_timing_ctrl: phase lengths must be >= 1 and axis totals <= 1024");
   end

   vga_phase_t         hPhase, vPhase;
   logic [COORD_W-1:0] hCnt, vCnt;
   logic               hWrap;
   logic               vWrapUnused;
   logic               hAct, vAct;

   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               de_q, de_d;
   logic               lineStart_q, lineStart_d;
   logic               frameStart_q, frameStart_d;
   logic               hSyn_q, hSyn_d, vSyn_q, vSyn_d;
   logic [3:0]         r_q, r_d, g_q, g_d, b_q, b_d;
   logic               hs_q, hs_d, vs_q, vs_d;

   vga_axis_seq #(
      .ACT_LEN (H_ACTIVE),
      .FP_LEN  (H_FRONT),
      .SYN_LEN (H_SYNC),
      .BP_LEN  (H_BACK)
   ) uHorz (
      .clk     (clk),
      .rst     (rst),
      .advance (pix_ce),
      .phase_o (hPhase),
      .count_o (hCnt),
      .wrap    (hWrap)
   );

   vga_axis_seq #(
      .ACT_LEN (V_ACTIVE),
      .FP_LEN  (V_FRONT),
      .SYN_LEN (V_SYNC),
      .BP_LEN  (V_BACK)
   ) uVert (
      .clk     (clk),
      .rst     (rst),
      .advance (hWrap),
      .phase_o (vPhase),
      .count_o (vCnt),
      .wrap    (vWrapUnused)
   );

   assign hAct = (hPhase == PH_ACT);
   assign vAct = (vPhase == PH_ACT);

   // Stage one follows the scan position; stage two applies blanking and sync one step later.
   always_comb begin
      x_d          = hAct ? hCnt : x_q;
      y_d          = vAct ? vCnt : y_q;
      de_d         = hAct && vAct;
      lineStart_d  = hAct && (hCnt == '0);
      frameStart_d = lineStart_d && vAct && (vCnt == '0);
      hSyn_d       = (hPhase == PH_SYN);
      vSyn_d       = (vPhase == PH_SYN);
      r_d          = de_q ? r_in : 4'h0;
      g_d          = de_q ? g_in : 4'h0;
      b_d          = de_q ? b_in : 4'h0;
      hs_d         = ~hSyn_q;
      vs_d         = ~vSyn_q;
   end

   // Output pipeline registers, all frozen while the pixel enable is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         de_q         <= 1'b0;
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
         hSyn_q       <= 1'b0;
         vSyn_q       <= 1'b0;
         r_q          <= 4'h0;
         g_q          <= 4'h0;
         b_q          <= 4'h0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
      end else if (pix_ce) begin
         x_q          <= x_d;
         y_q          <= y_d;
         de_q         <= de_d;
         lineStart_q  <= lineStart_d;
         frameStart_q <= frameStart_d;
         hSyn_q       <= hSyn_d;
         vSyn_q       <= vSyn_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frameCnt_q;

   // Frame counter steps on the same edge that raises the frame pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frameCnt_q <= 8'd0;
      end else if (pix_ce && frameStart_d) begin
         frameCnt_q <= frameCnt_q + 8'd1;
      end
   end

   assign frame_cnt = frameCnt_q;
`endif

   assign x           = x_q;
   assign y           = y_q;
   assign de          = de_q;
   assign line_start  = lineStart_q && pix_ce;
   assign frame_start = frameStart_q && pix_ce;
   assign r           = r_q;
   assign g           = g_q;
   assign b           = b_q;
   assign hs          = hs_q;
   assign vs          = vs_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl with a shrunken raster so whole frames fit
// in a short run. Expected outputs come from the number of pixel-enable
// edges since reset, turned into a raster position with plain arithmetic.
module tb_vga_timing_ctrl;

   localparam int HA = 20;
   localparam int HF = 1;
   localparam int HS = 4;
   localparam int HB = 5;
   localparam int VA = 6;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic       clk = 1'b0;
   logic       rst;
   logic       pixCe;
   logic [9:0] x, y;
   logic       de, lineStart, frameStart;
   logic [3:0] rIn, gIn, bIn;
   logic [3:0] r, g, b;
   logic       hs, vs;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frameCnt;
`endif

   int         total = 0;
   int         bad = 0;
   int         k = 0;
   logic [3:0] lastR = 4'h0, lastG = 4'h0, lastB = 4'h0;

   vga_timing_ctrl #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_ce      (pixCe),
      .x           (x),
      .y           (y),
      .de          (de),
      .line_start  (lineStart),
      .frame_start (frameStart),
      .r_in        (rIn),
      .g_in        (gIn),
      .b_in        (bIn),
      .r           (r),
      .g           (g),
      .b           (b),
      .hs          (hs),
      .vs          (vs)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_cnt   (frameCnt)
`endif
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Column and line of a raster position counted from the top-left pixel.
   function automatic int colOf(input int p);
      return p % HT;
   endfunction

   function automatic int lineOf(input int p);
      return (p / HT) % VT;
   endfunction

   function automatic logic visibleAt(input int p);
      return (colOf(p) < HA) && (lineOf(p) < VA);
   endfunction

   // Single comparison point: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
      end
   endtask

   // Compares every output with what the raster model predicts for the current edge count.
   task automatic checkScan();
      int p, q;
      int ex, ey, ede, els, efs, ehs, evs, er, eg, eb;
      ex = 0; ey = 0; ede = 0; els = 0; efs = 0;
      ehs = 1; evs = 1; er = 0; eg = 0; eb = 0;
      if (k >= 1) begin
         p   = k - 1;
         ex  = (colOf(p) < HA) ? colOf(p) : HA - 1;
         ey  = (lineOf(p) < VA) ? lineOf(p) : VA - 1;
         ede = int'(visibleAt(p));
         els = int'(colOf(p) == 0 && pixCe === 1'b1);
         efs = int'((p % FT) == 0 && pixCe === 1'b1);
      end
      if (k >= 2) begin
         q   = k - 2;
         ehs = int'(!(colOf(q) >= HA + HF && colOf(q) < HA + HF + HS));
         evs = int'(!(lineOf(q) >= VA + VF && lineOf(q) < VA + VF + VS));
         if (visibleAt(q)) begin
            er = int'(lastR);
            eg = int'(lastG);
            eb = int'(lastB);
         end
      end
      checkOutput("x", 32'(x), 32'(ex));
      checkOutput("y", 32'(y), 32'(ey));
      checkOutput("de", 32'(de), 32'(ede));
      checkOutput("line_start", 32'(lineStart), 32'(els));
      checkOutput("frame_start", 32'(frameStart), 32'(efs));
      checkOutput("hs", 32'(hs), 32'(ehs));
      checkOutput("vs", 32'(vs), 32'(evs));
      checkOutput("r", 32'(r), 32'(er));
      checkOutput("g", 32'(g), 32'(eg));
      checkOutput("b", 32'(b), 32'(eb));
`ifdef VGA_FRAME_COUNT_EN
      checkOutput("frame_cnt", 32'(frameCnt), (k == 0) ? 32'd0 : 32'((((k - 1) / FT) + 1) % 256));
`endif
   endtask

   // One clock: account for an enabled edge, then drive new enable/colour.
   // mode 0 random enable, 1 enable high, 2 enable low, 3 toggle enable.
   task automatic applyStimulus(input int mode);
      @(posedge clk);
      if (pixCe && !rst) begin
         k++;
         lastR = rIn;
         lastG = gIn;
         lastB = bIn;
      end
      #1;
      case (mode)
         0:       pixCe = ($urandom_range(0, 3) != 0);
         1:       pixCe = 1'b1;
         2:       pixCe = 1'b0;
         default: pixCe = ~pixCe;
      endcase
      rIn = 4'($urandom);
      gIn = 4'($urandom);
      bIn = 4'($urandom);
      @(negedge clk);
   endtask

   // Directed sequence: reset, full-rate frames, random and toggled enable,
   // a long enable stall inside sync, then a mid-frame reset and restart.
   initial begin
      bit found;
      rst   = 1'b1;
      pixCe = 1'b0;
      rIn   = 4'h0;
      gIn   = 4'h0;
      bIn   = 4'h0;
      repeat (3) @(negedge clk);
      $display("[TB] reset values");
      checkScan();

      rst   = 1'b0;
      pixCe = 1'b1;
      #1;
      checkScan();

      $display("[TB] first enabled cycle and full-rate frames");
      applyStimulus(1);
      checkOutput("first_frame_start", 32'(frameStart), 32'd1);
      checkScan();
      for (int i = 0; i < 2 * FT + 40; i++) begin
         applyStimulus(1);
         checkScan();
      end

      $display("[TB] random pixel enable");
      for (int i = 0; i < 900; i++) begin
         applyStimulus(0);
         checkScan();
      end

      $display("[TB] toggled pixel enable");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(3);
         checkScan();
      end

      $display("[TB] long enable stall inside horizontal sync");
      found = 1'b0;
      for (int i = 0; i < 3 * HT && !found; i++) begin
         applyStimulus(1);
         checkScan();
         if (hs === 1'b0) found = 1'b1;
      end
      checkOutput("hs_reached", 32'(found), 32'd1);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(2);
         checkScan();
      end
      for (int i = 0; i < 2 * HT; i++) begin
         applyStimulus(1);
         checkScan();
      end

      $display("[TB] reset in the middle of a visible line");
      found = 1'b0;
      for (int i = 0; i < FT + 5 && !found; i++) begin
         applyStimulus(1);
         checkScan();
         if (k >= 1 && ((k - 1) % FT) == 4 * HT + 15) found = 1'b0 | 1'b1;
      end
      checkOutput("mid_frame_reached", 32'(found), 32'd1);
      checkOutput("mid_frame_x", 32'(x), 32'd15);
      checkOutput("mid_frame_y", 32'(y), 32'd4);
      #2;
      rst = 1'b1;
      k   = 0;
      #1;
      checkScan();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0);
         checkScan();
      end
      rst = 1'b0;
      for (int i = 0; i < FT + 20; i++) begin
         applyStimulus(1);
         checkScan();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
